trust_port_selector: RTL and testbench

Parametrised, trust-weighted output-port selector for the NoC router. Keeps a saturating trust counter per output port, dispatches each routing request to the most-trusted eligible candidate port, tracks one outstanding packet per port awaiting acknowledgment, and rewards acknowledgments and penalises timeouts. It sits between route computation, which supplies the candidate-port mask, and the crossbar/output stage, which consumes the grant.

---
 rtl/trust_port_selector.sv | 187 ++++++++++++++++++
 tb/tb_trust_port_selector.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trust_port_selector.sv
// Trust-weighted output-port selector.
// Keeps a saturating trust score per output port and sends each routing request
// to the most-trusted eligible candidate. Each port can have one packet in flight.
// An acknowledgment raises that port's trust. A timeout lowers it.
//
// Per-port state table:
//   state      | meaning
//   ST_IDLE    | no packet outstanding; port may be selected
//   ST_PENDING | packet dispatched, waiting for ack; timer counts cycles
module trust_port_selector #(
  parameter int NUM_PORTS  = 4,
  parameter int TRUST_W    = 4,
  parameter int TRUST_INIT = 8,
  parameter int INC        = 1,
  parameter int DEC        = 2,
  parameter int TIMEOUT    = 16,
  parameter int QUARANTINE = 1,
  parameter int PW         = $clog2(NUM_PORTS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic [NUM_PORTS-1:0]         req_mask,
  output logic                         req_ready,
  output logic                         grant_valid,
  output logic [PW-1:0]                grant_port,
  input  logic                         ack_valid,
  input  logic [PW-1:0]                ack_port,
  output logic [NUM_PORTS*TRUST_W-1:0] trust_levels,
  output logic [NUM_PORTS-1:0]         pending,
  output logic [NUM_PORTS-1:0]         timeout_evt,
  output logic                         stray_ack
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TRUST_W:0] TRUST_MAX_W = {1'b0, {TRUST_W{1'b1}}};
  // The timer holds 0 right after dispatch, so expiry is detected one count early.
  // This makes timeout_evt rise in the cycle after edge dispatch+TIMEOUT.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic {ST_IDLE, ST_PENDING} port_state_t;

  port_state_t          state_q [NUM_PORTS];
  port_state_t          state_d [NUM_PORTS];
  logic [TRUST_W-1:0]   trust_q [NUM_PORTS];
  logic [TRUST_W-1:0]   trust_d [NUM_PORTS];
  logic [TMR_W-1:0]     timer_q [NUM_PORTS];
  logic [TMR_W-1:0]     timer_d [NUM_PORTS];

  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] ack_onehot;
  logic [NUM_PORTS-1:0] tevt_d;
  logic                 sel_found;
  logic [PW-1:0]        sel_port;
  logic [TRUST_W-1:0]   sel_trust;
  logic                 accept;
  logic                 stray_d;

  // Add the reward at TRUST_W+1 bits, then clamp to the counter's maximum.
  function automatic logic [TRUST_W-1:0] sat_inc(input logic [TRUST_W-1:0] t);
    logic [TRUST_W:0] sum;
    sum = {1'b0, t} + (TRUST_W+1)'(INC);
    if (sum > TRUST_MAX_W) return TRUST_MAX_W[TRUST_W-1:0];
    return sum[TRUST_W-1:0];
  endfunction

  // Subtract the penalty, clamping at zero instead of wrapping.
  function automatic logic [TRUST_W-1:0] sat_dec(input logic [TRUST_W-1:0] t);
    if (int'(t) < DEC) return '0;
    return TRUST_W'(int'(t) - DEC);
  endfunction

  // Expose registered per-port state on the packed status outputs.
  always_comb begin
    trust_levels = '0;
    pending      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      trust_levels[i*TRUST_W +: TRUST_W] = trust_q[i];
      pending[i] = (state_q[i] == ST_PENDING);
    end
  end

  // Eligibility uses only registered state, so ack_valid cannot reach req_ready.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = req_mask[i] && !pending[i] &&
                    ((QUARANTINE == 0) || (trust_q[i] != '0));
    end
  end

  assign req_ready = |eligible;
  assign accept    = req_valid && req_ready;

  // Pick the highest-trust eligible port. Only a strict improvement replaces the
  // current choice, so a tie goes to the lowest index.
  always_comb begin
    sel_found = 1'b0;
    sel_port  = '0;
    sel_trust = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (eligible[i] && (!sel_found || (trust_q[i] > sel_trust))) begin
        sel_found = 1'b1;
        sel_port  = PW'(i);
        sel_trust = trust_q[i];
      end
    end
  end

  // Decode the ack target. An out-of-range index matches no port and counts as stray.
  always_comb begin
    ack_onehot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      ack_onehot[i] = ack_valid && (ack_port == PW'(i));
    end
    stray_d = ack_valid && !(|(ack_onehot & pending));
  end

  // Compute the next state of each port. An ack takes priority over a timeout on the same edge.
  always_comb begin
    tevt_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      state_d[i] = state_q[i];
      trust_d[i] = trust_q[i];
      timer_d[i] = timer_q[i];
      case (state_q[i])
        ST_IDLE: begin
          timer_d[i] = '0;
          if (accept && (sel_port == PW'(i))) begin
            state_d[i] = ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (ack_onehot[i]) begin
            state_d[i] = ST_IDLE;
            timer_d[i] = '0;
            trust_d[i] = sat_inc(trust_q[i]);
          end else if (timer_q[i] == TMR_LAST) begin
            state_d[i] = ST_IDLE;
            timer_d[i] = '0;
            trust_d[i] = sat_dec(trust_q[i]);
            tevt_d[i]  = 1'b1;
          end else begin
            timer_d[i] = timer_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          timer_d[i] = '0;
        end
      endcase
    end
  end

  // Register the per-port state. Reset drops outstanding packets without any penalty.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i] <= ST_IDLE;
        trust_q[i] <= TRUST_W'(TRUST_INIT);
        timer_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i] <= state_d[i];
        trust_q[i] <= trust_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

  // Register the grant and event pulses. grant_port keeps its last value while grant_valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_valid <= 1'b0;
      grant_port  <= '0;
      timeout_evt <= '0;
      stray_ack   <= 1'b0;
    end else begin
      grant_valid <= accept;
      if (accept) grant_port <= sel_port;
      timeout_evt <= tevt_d;
      stray_ack   <= stray_d;
    end
  end

endmodule

// File: tb/tb_trust_port_selector.sv
// Testbench for trust_port_selector. Runs directed scenarios first, then random traffic.
// All expected values come from an edge-counting reference model kept in this bench.
module tb_trust_port_selector;

  localparam int NP      = 4;
  localparam int TW      = 4;
  localparam int TINIT   = 8;
  localparam int INC     = 1;
  localparam int DEC     = 2;
  localparam int TIMEOUT = 16;
  localparam int TMAX    = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [NP-1:0] req_mask = '0;
  logic          req_ready;
  logic          grant_valid;
  logic [1:0]    grant_port;
  logic          ack_valid = 1'b0;
  logic [1:0]    ack_port = '0;
  logic [NP*TW-1:0] trust_levels;
  logic [NP-1:0] pending;
  logic [NP-1:0] timeout_evt;
  logic          stray_ack;

  trust_port_selector #(
    .NUM_PORTS(NP), .TRUST_W(TW), .TRUST_INIT(TINIT), .INC(INC), .DEC(DEC),
    .TIMEOUT(TIMEOUT), .QUARANTINE(1)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_mask(req_mask),
    .req_ready(req_ready), .grant_valid(grant_valid), .grant_port(grant_port),
    .ack_valid(ack_valid), .ack_port(ack_port), .trust_levels(trust_levels),
    .pending(pending), .timeout_evt(timeout_evt), .stray_ack(stray_ack)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int fails  = 0;

  // Reference model state.
  // Timeouts are found by comparing edge numbers, not by running a timer.
  int   m_trust [NP];
  bit   m_pend  [NP];
  int   m_disp  [NP];
  int   edge_n;
  logic       exp_gv;
  logic [1:0] exp_gp;
  logic [NP-1:0] exp_tevt;
  logic       exp_stray;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NP*TW-1:0] model_trust();
    logic [NP*TW-1:0] v;
    v = '0;
    for (int p = 0; p < NP; p++) v[p*TW +: TW] = TW'(m_trust[p]);
    return v;
  endfunction

  function automatic logic [NP-1:0] model_pend();
    logic [NP-1:0] v;
    v = '0;
    for (int p = 0; p < NP; p++) v[p] = m_pend[p];
    return v;
  endfunction

  task automatic chk_outputs();
    chk("grant_valid", 32'(grant_valid), 32'(exp_gv));
    if (exp_gv) chk("grant_port", 32'(grant_port), 32'(exp_gp));
    chk("pending", 32'(pending), 32'(model_pend()));
    chk("trust_levels", 32'(trust_levels), 32'(model_trust()));
    chk("timeout_evt", 32'(timeout_evt), 32'(exp_tevt));
    chk("stray_ack", 32'(stray_ack), 32'(exp_stray));
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_trust[p] = TINIT;
      m_pend[p]  = 0;
      m_disp[p]  = 0;
    end
    exp_gv = 0; exp_gp = '0; exp_tevt = '0; exp_stray = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0; ack_valid = 1'b0; req_mask = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk_outputs();
  endtask

  // Run one cycle: drive inputs, check req_ready, advance the model by one edge,
  // then check the registered outputs.
  task automatic step(input logic v, input logic [NP-1:0] mask, input logic av,
                      input logic [1:0] ap);
    logic [NP-1:0] elig;
    logic rdy;
    int sel, best;
    req_valid = v; req_mask = mask; ack_valid = av; ack_port = ap;
    #1;
    for (int p = 0; p < NP; p++) elig[p] = mask[p] && !m_pend[p] && (m_trust[p] != 0);
    rdy = |elig;
    chk("req_ready", 32'(req_ready), 32'(rdy));
    sel = 0; best = -1;
    for (int p = 0; p < NP; p++)
      if (elig[p] && m_trust[p] > best) begin best = m_trust[p]; sel = p; end
    edge_n++;
    exp_gv = v && rdy;
    if (exp_gv) exp_gp = 2'(sel);
    exp_tevt = '0; exp_stray = 0;
    if (av) begin
      if (m_pend[ap]) begin
        m_pend[ap] = 0;
        m_trust[ap] = (m_trust[ap] + INC > TMAX) ? TMAX : m_trust[ap] + INC;
      end else exp_stray = 1;
    end
    for (int p = 0; p < NP; p++)
      if (m_pend[p] && edge_n == m_disp[p] + TIMEOUT) begin
        m_pend[p] = 0;
        m_trust[p] = (m_trust[p] < DEC) ? 0 : m_trust[p] - DEC;
        exp_tevt[p] = 1'b1;
      end
    if (exp_gv) begin m_pend[sel] = 1; m_disp[sel] = edge_n; end
    @(posedge clk); #1;
    req_valid = 1'b0; ack_valid = 1'b0;
    chk_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 2'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    edge_n = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset();
    chk("reset_trust", 32'(trust_levels), 32'h8888);

    // With all trust equal, the lowest index wins. The next request goes to port 1.
    step(1'b1, 4'b1111, 1'b0, 2'd0);
    chk("first_grant", 32'(grant_port), 32'd0);
    chk("first_pend", 32'(pending), 32'b0001);
    step(1'b1, 4'b1111, 1'b0, 2'd0);
    chk("second_grant", 32'(grant_port), 32'd1);
    step(1'b0, '0, 1'b1, 2'd0);
    step(1'b0, '0, 1'b1, 2'd1);

    // Reward port 2 three times, then the higher trust wins a contested request.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'b0100, 1'b0, 2'd0);
      step(1'b0, '0, 1'b1, 2'd2);
    end
    chk("trust2_11", 32'(trust_levels[2*TW +: TW]), 32'd11);
    step(1'b1, 4'b0110, 1'b0, 2'd0);
    chk("trust_pick", 32'(grant_port), 32'd2);
    step(1'b0, '0, 1'b1, 2'd2);

    // Time port 3 out repeatedly until it reaches zero trust and is quarantined.
    for (int r = 0; r < 4; r++) begin
      step(1'b1, 4'b1000, 1'b0, 2'd0);
      idle(TIMEOUT);
      if (r == 0) chk("timeout_trust3", 32'(trust_levels[3*TW +: TW]), 32'd6);
    end
    chk("trust3_zero", 32'(trust_levels[3*TW +: TW]), 32'd0);
    step(1'b1, 4'b1000, 1'b0, 2'd0);
    chk("quarantine_ready", 32'(req_ready), 32'd0);

    // Push port 2 to the 15 ceiling. Another ack must not wrap, and an idle ack is stray.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 4'b0100, 1'b0, 2'd0);
      step(1'b0, '0, 1'b1, 2'd2);
    end
    chk("sat15", 32'(trust_levels[2*TW +: TW]), 32'd15);
    step(1'b0, '0, 1'b1, 2'd2);
    chk("stray_pulse", 32'(stray_ack), 32'd1);
    chk("stray_trust", 32'(trust_levels[2*TW +: TW]), 32'd15);

    // An ack on the exact timeout edge wins, so trust goes up and no timeout_evt fires.
    step(1'b1, 4'b0001, 1'b0, 2'd0);
    idle(TIMEOUT - 1);
    step(1'b0, '0, 1'b1, 2'd0);
    chk("race_no_evt", 32'(timeout_evt), 32'd0);
    chk("race_trust0", 32'(trust_levels[0 +: TW]), 32'd10);

    // An ack to port 0 and a dispatch to port 1 take effect on the same edge.
    step(1'b1, 4'b0001, 1'b0, 2'd0);
    step(1'b1, 4'b0010, 1'b1, 2'd0);
    chk("concurrent_pend", 32'(pending), 32'b0010);
    chk("concurrent_trust0", 32'(trust_levels[0 +: TW]), 32'd11);

    // Reset with three ports pending drops all packets and applies no penalty.
    step(1'b1, 4'b0001, 1'b0, 2'd0);
    step(1'b1, 4'b0100, 1'b0, 2'd0);
    chk("three_pending", 32'(pending), 32'b0111);
    do_reset();
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_trust", 32'(trust_levels), 32'h8888);
    chk("rst_gv", 32'(grant_valid), 32'd0);

    // Random traffic. Acks are biased toward ports that are actually pending.
    for (int c = 0; c < 600; c++) begin
      logic v, av;
      logic [NP-1:0] m;
      logic [1:0] ap;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        continue;
      end
      v  = ($urandom_range(0, 99) < 60);
      m  = NP'($urandom);
      av = ($urandom_range(0, 99) < 35);
      ap = 2'($urandom);
      if (av && $urandom_range(0, 99) < 75) begin
        for (int t = 0; t < 4; t++) begin
          int q;
          q = (int'(ap) + t) % NP;
          if (m_pend[q]) begin ap = 2'(q); break; end
        end
      end
      step(v, m, av, ap);
    end

    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end

endmodule
